piso_shift_tx: RTL and testbench



---
 rtl/piso_shift_tx_pkg.sv | 18 +
 rtl/piso_bit_cnt.sv | 33 +++
 rtl/piso_shift_tx.sv | 120 ++++++++++++
 tb/tb_piso_shift_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_shift_tx_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
package piso_shift_tx_pkg;

    // Two-state transmitter FSM encoding.
    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    // Level driven on the serial line while no frame is in flight.
    localparam logic SOUT_IDLE = 1'b0;

    // Bit-counter width: wide enough to hold the values 0..FLEN.
    function automatic int cnt_width(input int flen);
        return $clog2(flen + 1);
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Loadable up-counter tracking which frame bit is on the serial line,
// with a terminal-count flag raised while the last frame bit is shown.
module piso_bit_cnt
    import piso_shift_tx_pkg::*;
#(
    parameter int FLEN = 6,
    parameter int CW   = cnt_width(FLEN)
) (
    input  logic clk,
    input  logic clear_n,
    input  logic i_load,
    input  logic i_inc,
    output logic o_tc
);

    localparam logic [CW-1:0] TC_VAL = CW'(FLEN - 1);

    logic [CW-1:0] r_count;

    // Restart at bit 0 on a frame load, otherwise advance while shifting.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: captures a word on an accepted
// load and drives it out one bit per clock, optionally followed by an
// even-parity bit. Frames may be chained with no idle gap.
module piso_shift_tx
    import piso_shift_tx_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter bit LSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             busy,
    output logic             sout,
    output logic             done
);

    localparam int FLEN = WIDTH + (PARITY_EN ? 1 : 0);

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [FLEN-1:0]  r_shift;
    logic             r_sout;
    logic [WIDTH-1:0] w_data;
    logic [FLEN-1:0]  w_frame;
    logic             w_tc;
    logic             w_accept;
    logic             w_shifting;

    // Reorder the data bits so that frame bit k is always at index k.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_data[i] = LSB_FIRST ? din[i] : din[WIDTH-1-i];
        end
    end

    // The parity bit, when present, is the last bit of the frame.
    generate
        if (PARITY_EN) begin : g_par
            assign w_frame = {^din, w_data};
        end else begin : g_nopar
            assign w_frame = w_data;
        end
    endgenerate

    assign w_accept   = load && ready;
    assign w_shifting = (r_state == TX_SHIFT);

    piso_bit_cnt #(
        .FLEN (FLEN)
    ) u_bit_cnt (
        .clk     (clk),
        .clear_n (clear_n),
        .i_load  (w_accept),
        .i_inc   (w_shifting),
        .o_tc    (w_tc)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs; the last-bit cycle also accepts a load.
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            TX_IDLE: begin
                ready = 1'b1;
                if (load) begin
                    w_state_nxt = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                busy  = 1'b1;
                done  = w_tc;
                ready = w_tc;
                if (w_tc && !load) begin
                    w_state_nxt = TX_IDLE;
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
            end
        endcase
    end

    // Bit 0 goes straight to the output flop on load; the rest shift down behind it.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_shift <= '0;
            r_sout  <= SOUT_IDLE;
        end else if (w_accept) begin
            r_sout  <= w_frame[0];
            r_shift <= w_frame >> 1;
        end else if (w_shifting) begin
            if (w_tc) begin
                r_sout  <= SOUT_IDLE;
                r_shift <= '0;
            end else begin
                r_sout  <= r_shift[0];
                r_shift <= r_shift >> 1;
            end
        end
    end

    assign sout = r_sout;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: three configurations (LSB-first, MSB-first,
// LSB-first with parity) share one stimulus stream and are compared every
// cycle against a frame-queue model, plus literal waveform expectations.
module tb_piso_shift_tx;

    logic       clk = 1'b0;
    logic       clear_n = 1'b1;
    logic       load = 1'b0;
    logic [5:0] din = '0;
    logic [2:0] sout_w, busy_w, done_w, ready_w;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(6), .LSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_a (
        .clk(clk), .clear_n(clear_n), .load(load), .din(din),
        .ready(ready_w[0]), .busy(busy_w[0]), .sout(sout_w[0]), .done(done_w[0]));

    piso_shift_tx #(.WIDTH(6), .LSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_b (
        .clk(clk), .clear_n(clear_n), .load(load), .din(din),
        .ready(ready_w[1]), .busy(busy_w[1]), .sout(sout_w[1]), .done(done_w[1]));

    piso_shift_tx #(.WIDTH(6), .LSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_c (
        .clk(clk), .clear_n(clear_n), .load(load), .din(din),
        .ready(ready_w[2]), .busy(busy_w[2]), .sout(sout_w[2]), .done(done_w[2]));

    function automatic bit cfg_lsb(input int c);
        return (c != 1);
    endfunction

    function automatic bit cfg_par(input int c);
        return (c == 2);
    endfunction

    // Frame as a bit list: element k is the k-th bit put on the line.
    function automatic logic [6:0] frame_of(input bit lsb, input bit par, input logic [5:0] d);
        logic [6:0] f;
        f = '0;
        for (int k = 0; k < 6; k++) f[k] = lsb ? d[k] : d[5-k];
        if (par) f[6] = ^d;
        return f;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Model: pending bits of the current frame, and what is on the line now.
    logic [6:0] m_pend[3];
    int         m_cnt[3];
    logic       m_cur[3];
    logic       m_valid[3];
    logic       m_last[3];

    initial begin
        for (int c = 0; c < 3; c++) begin
            m_pend[c] = '0; m_cnt[c] = 0; m_cur[c] = 1'b0;
            m_valid[c] = 1'b0; m_last[c] = 1'b0;
        end
    end

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int c = 0; c < 3; c++) begin
                m_pend[c] <= '0; m_cnt[c] <= 0; m_cur[c] <= 1'b0;
                m_valid[c] <= 1'b0; m_last[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                automatic logic [6:0] p = m_pend[c];
                automatic int         n = m_cnt[c];
                automatic bit         rdy = !m_valid[c] || m_last[c];
                if (rdy && load) begin
                    p = frame_of(cfg_lsb(c), cfg_par(c), din);
                    n = cfg_par(c) ? 7 : 6;
                end
                if (n > 0) begin
                    m_cur[c]   <= p[0];
                    p          = p >> 1;
                    n          = n - 1;
                    m_valid[c] <= 1'b1;
                    m_last[c]  <= (n == 0);
                end else begin
                    m_cur[c]   <= 1'b0;
                    m_valid[c] <= 1'b0;
                    m_last[c]  <= 1'b0;
                end
                m_pend[c] <= p;
                m_cnt[c]  <= n;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (chk_en) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("sout%0d cyc%0d", c, cyc), sout_w[c], m_cur[c]);
                check($sformatf("busy%0d cyc%0d", c, cyc), busy_w[c], m_valid[c]);
                check($sformatf("done%0d cyc%0d", c, cyc), done_w[c], m_last[c]);
                check($sformatf("ready%0d cyc%0d", c, cyc), ready_w[c], !m_valid[c] || m_last[c]);
            end
        end
    end

    logic [63:0] cap_s[3];
    logic [63:0] cap_b[3];
    logic [63:0] cap_d[3];

    // Iteration i drives the inputs seen by the next edge, then records outputs.
    task automatic directed(input int n, input logic [63:0] lmask,
                            input logic [5:0] da, input logic [5:0] db);
        for (int c = 0; c < 3; c++) begin
            cap_s[c] = '0; cap_b[c] = '0; cap_d[c] = '0;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            load = lmask[i];
            din  = (i == 0) ? da : db;
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                cap_s[c][i] = sout_w[c];
                cap_b[c][i] = busy_w[c];
                cap_d[c][i] = done_w[c];
            end
        end
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        load = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2 clear_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("rst sout%0d", c), sout_w[c], 1'b0);
            check($sformatf("rst busy%0d", c), busy_w[c], 1'b0);
            check($sformatf("rst done%0d", c), done_w[c], 1'b0);
            check($sformatf("rst ready%0d", c), ready_w[c], 1'b1);
        end
        repeat (3) @(posedge clk);
        #1 clear_n = 1'b1;
        chk_en = 1'b1;
        idle(3);

        // Single frame of 6'b000111; later din changes must not matter.
        directed(9, 64'h1, 6'b000111, 6'b101010);
        check_vec("basic lsb sout", cap_s[0], 64'h00E);
        check_vec("basic lsb busy", cap_b[0], 64'h07E);
        check_vec("basic lsb done", cap_d[0], 64'h040);
        check_vec("basic msb sout", cap_s[1], 64'h070);
        check_vec("basic msb done", cap_d[1], 64'h040);
        check_vec("parity sout", cap_s[2], 64'h08E);
        check_vec("parity busy", cap_b[2], 64'h0FE);
        check_vec("parity done", cap_d[2], 64'h080);
        idle(4);

        directed(9, 64'h1, 6'b000011, 6'b000000);
        check_vec("parity0 sout", cap_s[2], 64'h006);
        check_vec("parity0 done", cap_d[2], 64'h080);
        idle(4);

        // Load during bit 2 is ignored.
        directed(9, 64'h9, 6'b000111, 6'b111111);
        check_vec("midload lsb sout", cap_s[0], 64'h00E);
        check_vec("midload lsb done", cap_d[0], 64'h040);
        idle(4);

        // Back-to-back: second load during the done cycle.
        directed(14, 64'h41, 6'b000111, 6'b111000);
        check_vec("b2b lsb sout", cap_s[0], 64'h1C0E);
        check_vec("b2b lsb busy", cap_b[0], 64'h1FFE);
        check_vec("b2b lsb done", cap_d[0], 64'h1040);
        check_vec("b2b msb sout", cap_s[1], 64'h03F0);
        idle(6);

        // Asynchronous reset mid-frame, after three bits of 6'b000111.
        @(posedge clk); #1 load = 1'b1; din = 6'b000111;
        @(posedge clk); #1 load = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        clear_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("async sout%0d", c), sout_w[c], 1'b0);
            check($sformatf("async busy%0d", c), busy_w[c], 1'b0);
            check($sformatf("async done%0d", c), done_w[c], 1'b0);
            check($sformatf("async ready%0d", c), ready_w[c], 1'b1);
        end
        // Release with load already high: honoured on the first edge after.
        load = 1'b1; din = 6'b110101;
        @(posedge clk); @(posedge clk); #3;
        clear_n = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        check("relload sout", sout_w[0], 1'b1);
        check("relload busy", busy_w[0], 1'b1);
        check("relload msb sout", sout_w[1], 1'b1);
        idle(10);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            load    = ($urandom_range(0, 2) == 0);
            din     = 6'($urandom);
            clear_n = ($urandom_range(0, 149) != 0);
        end
        @(posedge clk); #1;
        clear_n = 1'b1;
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
